// File: rtl/sync_register_bank_if.sv
// rtl/sync_register_bank_if.sv - register access bus for sync_register_bank
interface sync_register_bank_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                    en;
    logic                    rd;
    logic                    wr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;

    modport master (output en, rd, wr, be, addr, wdata, input rdata, rvalid);
    modport slave  (input en, rd, wr, be, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/sync_register_bank.sv
// rtl/sync_register_bank.sv - register bank with RO, shadowed, trigger and W1C status registers
module sync_register_bank #(
    parameter int                  ADDR_WIDTH  = 4,
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK     = 'h0300,
    parameter logic [NUM_REGS-1:0] SHADOW_MASK = 'h3000,
    parameter int                  TRIG_ADDR   = 1,
    parameter int                  STAT_ADDR   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    sync_register_bank_if.slave            bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_values,
    output logic [NUM_REGS*DATA_WIDTH-1:0] values,
    input  logic                           commit,
    input  logic [DATA_WIDTH-1:0]          status_set,
    output logic [DATA_WIDTH-1:0]          trigger
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  rd_go;
    logic                  wr_go;
    logic                  trig_wr;
    logic                  stat_wr;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rd_word [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] status_q;
    logic [DATA_WIDTH-1:0] trigger_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // A simultaneous read and write is treated as a read only.
    assign rd_go = bus.en && bus.rd;
    assign wr_go = bus.en && bus.wr && !bus.rd;

    always_comb begin
        wmask = '0;
        for (int k = 0; k < NB; k++) begin
            wmask[8*k +: 8] = {8{bus.be[k]}};
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = wr_go && (bus.addr == ADDR_WIDTH'(i)) && !RO_MASK[i];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == TRIG_ADDR) begin : g_trig
            assign trig_wr                               = wr_sel[i];
            assign values[i*DATA_WIDTH +: DATA_WIDTH]    = '0;
            assign rd_word[i]                            = '0;
        end else if (i == STAT_ADDR) begin : g_stat
            assign stat_wr                               = wr_sel[i];
            assign values[i*DATA_WIDTH +: DATA_WIDTH]    = status_q;
            assign rd_word[i]                            = status_q;
        end else if (RO_MASK[i]) begin : g_ro
            assign values[i*DATA_WIDTH +: DATA_WIDTH]    = ro_values[i*DATA_WIDTH +: DATA_WIDTH];
            assign rd_word[i]                            = ro_values[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            // For shadowed registers store_q is the pending shadow copy.
            logic [DATA_WIDTH-1:0] store_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    store_q <= '0;
                end else if (wr_sel[i]) begin
                    store_q <= (store_q & ~wmask) | (bus.wdata & wmask);
                end
            end
            assign rd_word[i] = store_q;

            if (SHADOW_MASK[i]) begin : g_shadow
                logic [DATA_WIDTH-1:0] active_q;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        active_q <= '0;
                    end else if (commit) begin
                        active_q <= store_q;
                    end
                end
                assign values[i*DATA_WIDTH +: DATA_WIDTH] = active_q;
            end else begin : g_plain
                assign values[i*DATA_WIDTH +: DATA_WIDTH] = store_q;
            end
        end
    end

    if (TRIG_ADDR >= NUM_REGS) begin : g_no_trig
        assign trig_wr = 1'b0;
    end
    if (STAT_ADDR >= NUM_REGS) begin : g_no_stat
        assign stat_wr = 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.addr == ADDR_WIDTH'(i)) begin
                rd_mux = rd_word[i];
            end
        end
    end

    // status_set is OR-ed in after the clear so a same-edge set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q  <= '0;
            trigger_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            status_q  <= (status_q & ~(stat_wr ? (bus.wdata & wmask) : '0)) | status_set;
            trigger_q <= trig_wr ? (bus.wdata & wmask) : '0;
            rvalid_q  <= rd_go;
            if (rd_go) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign trigger    = trigger_q;
    assign bus.rdata  = rdata_q;
    // Masking keeps a read accepted just before reset from pulsing rvalid during reset.
    assign bus.rvalid = rvalid_q && !reset;
endmodule

// File: doc/sync_register_bank.md
SYNC_REGISTER_BANK -- requirements
Module: sync_register_bank

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, meaning register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning register width, a multiple of 8.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, meaning implemented registers, at most 2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter RO_MASK, default 0x0300, meaning bit i set makes register i read-only and sourced from ro_values.
REQ-005 The block SHALL have parameter SHADOW_MASK, default 0x3000, meaning bit i set makes register i double-buffered.
REQ-006 The block SHALL have parameters TRIG_ADDR, default 1, and STAT_ADDR, default 2, meaning the trigger and status register addresses.
REQ-007 clk  in  1  system clock; one clock domain; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 en  in  1  access enable; rd and wr are ignored when low.
REQ-010 rd  in  1  read request.
REQ-011 wr  in  1  write request.
REQ-012 be  in  DATA_WIDTH/8  byte enables; bit k covers wdata[8k+7:8k].
REQ-013 addr  in  ADDR_WIDTH  register address.
REQ-014 wdata  in  DATA_WIDTH  write data.
REQ-015 rdata  out  DATA_WIDTH  registered read data.
REQ-016 rvalid  out  1  one-cycle pulse qualifying rdata.
REQ-017 ro_values  in  NUM_REGS*DATA_WIDTH  external read-only values, slice i belongs to register i.
REQ-018 values  out  NUM_REGS*DATA_WIDTH  active register contents, slice i belongs to register i.
REQ-019 commit  in  1  frame-boundary strobe that copies shadow registers to active registers.
REQ-020 status_set  in  DATA_WIDTH  per-bit set requests for the status register.
REQ-021 trigger  out  DATA_WIDTH  single-cycle command pulses.

Function
REQ-022 The block SHALL perform a write at a rising edge when en & wr & ~rd; en & wr & rd SHALL be treated as a read only.
REQ-023 A write SHALL update only the bytes whose be bit is set; bytes with be clear SHALL hold their value.
REQ-024 Writes SHALL be ignored when addr >= NUM_REGS or when addr selects an RO_MASK register.
REQ-025 A read accepted at edge N SHALL drive rdata and rvalid=1 during cycle N+1; rvalid SHALL be 0 in every other cycle, with rdata holding its last value.
REQ-026 Read data SHALL be: ro_values slice for RO registers; the pending shadow value for SHADOW registers; the status register for STAT_ADDR; 0 for TRIG_ADDR; the stored value otherwise; 0 when addr >= NUM_REGS.
REQ-027 The values slice for an RO register SHALL equal ro_values combinationally; the TRIG_ADDR slice SHALL be 0.
REQ-028 A write to a SHADOW register SHALL update only its shadow copy; the active copy SHALL load the full shadow word on the edge where commit=1.
REQ-029 When a write and commit coincide on one shadow register, the active copy SHALL take the pre-write shadow value, and the shadow SHALL take the new write; the new value SHALL appear on the next commit.
REQ-030 A write to TRIG_ADDR SHALL assert trigger bits equal to the byte-enabled wdata bits for exactly one cycle after the write edge; trigger SHALL otherwise be 0, including on back-to-back writes, which give back-to-back pulses.
REQ-031 Status bits SHALL be write-1-to-clear through byte-enabled wdata at STAT_ADDR and SHALL be set by status_set; when set and clear hit the same bit on one edge, set SHALL win.
REQ-032 A read of STAT_ADDR SHALL return the pre-edge value and SHALL NOT clear any bit.

Reset
REQ-033 On the rising edge where reset=1, all stored, shadow, active and status bits SHALL clear to 0 and rdata, rvalid and trigger SHALL be 0.
REQ-034 While reset=1, accesses, commit and status_set SHALL be ignored; operation SHALL resume on the first edge with reset=0.
REQ-035 A read accepted on the edge before reset asserts SHALL NOT produce rvalid during reset.

Verification
REQ-036 Write reg 0 wdata=0xABCD be=01, then read reg 0 -> rdata=0x00CD with rvalid high exactly one cycle after the read edge.
REQ-037 Write reg 12 =0x0123 -> values slice 12 stays 0 and a read returns 0x0123; pulse commit -> values slice 12 =0x0123.
REQ-038 Write reg 12 =0x0055 on the same edge as commit, with prior shadow 0x0123 -> active =0x0123; next commit -> 0x0055.
REQ-039 Write TRIG_ADDR =0x0011 be=11 -> trigger=0x0011 for one cycle, then 0x0000; a read returns 0.
REQ-040 status_set=0x0003, then write STAT_ADDR =0x0001 with status_set=0x0001 on the same edge -> status stays 0x0003; write 0x0003 alone -> 0x0000.
REQ-041 Set reg 0 =0x1F and ro_values slice 8 =0x2A5, assert reset for one cycle -> reg 0 reads 0, reg 8 reads 0x2A5, and a write to reg 8 has no effect.
